dp_bank_arbiter: RTL
====================

// Module: dp_bank_arbiter
// PURPOSE
// - Issue stage of the dual-port multi-bank memory; sits directly upstream of the bank-select decoder.
// - Accepts port A and port B requests (valid/ready) and splits each address into bank index and row.
// - Resolves same-bank conflicts with a two-state round-robin priority FSM.
// - Registers the granted requests. Each issued bank index drives one decoder input.
// PARAMETERS
// - ADDR_W    8  full request address width
// - A         2  bank-index width (MSBs of the address); matches the decoder's A
// - NUM_BANK  4  number of banks; must equal 2**A
// - DATA_W    8  write-data width
// PORTS
// - clk            in   1             single clock; all state changes on the rising edge
// - rst            in   1             synchronous, active-high reset
// - a_valid        in   1             port A request valid
// - a_ready        out  1             port A request accepted this cycle
// - a_we           in   1             port A: 1 = write, 0 = read
// - a_addr         in   ADDR_W        port A address
// - a_wdata        in   DATA_W        port A write data
// - b_valid / b_ready / b_we / b_addr / b_wdata   same as port A, for port B
// - a_iss_vld      out  1             port A issue valid (registered)
// - a_iss_bank     out  A             port A bank index, to decoder input
// - a_iss_row      out  ADDR_W-A      port A row = a_addr[ADDR_W-A-1:0]
// - a_iss_we       out  1             port A issued write enable
// - a_iss_wdata    out  DATA_W        port A issued write data
// - b_iss_*        out  (as a_iss_*)  port B issue outputs
// - conflict_cnt   out  16            present only when ARB_CONFLICT_CNT_EN is defined
// BEHAVIOUR
// - Bank index: bank_x = x_addr[ADDR_W-1 -: A].
// - Conflict: a_valid & b_valid & (bank_a == bank_b), regardless of we (read/read also conflicts).
// - FSM state prio, two states:
//   - PRIO_A: A wins a conflict.
//   - PRIO_B: B wins a conflict.
//   - Reset state: PRIO_A.
//   - On a conflict cycle, prio moves to the loser's state. Otherwise prio holds.
//   - The loser is therefore guaranteed to win the next conflict; no starvation.
// - Ready (combinational from valids, addresses and prio; low whenever rst = 1):
//   - No conflict: a_ready = a_valid, b_ready = b_valid.
//   - Conflict: only the winner's ready is high. The loser must hold valid and payload stable.
// - Transfer on x_valid & x_ready.
// - Latency: exactly 1 cycle.
//   - Next cycle: x_iss_vld = 1, and x_iss_bank / row / we / wdata carry the captured request.
//   - With no transfer: x_iss_vld = 0 and the payload outputs hold their last value.
// - Both ports may issue in the same cycle only when their banks differ.
// - Same-address cases (A write and B read, or both writes) are always conflicts. They are serialized in priority order, never merged.
// - Reset values: all x_iss_vld = 0; x_iss_bank, x_iss_row, x_iss_we, x_iss_wdata = 0; prio = PRIO_A; conflict_cnt = 0.
// - Reset mid-operation:
//   - Any request not yet transferred is dropped and the ready outputs go low.
//   - Issue registers clear on the reset edge.
//   - The first grant after reset release uses PRIO_A.
// - Valid deasserted by the loser (protocol violation): no transfer, and prio still toggles (conflict was seen).
// CONFIGURATION
// - ARB_CONFLICT_CNT_EN defined:
//   - Adds output conflict_cnt[15:0], incremented by 1 on every conflict cycle.
//   - Saturates at 16'hFFFF; cleared by rst.
// - ARB_CONFLICT_CNT_EN undefined:
//   - Port and counter logic absent. All other behaviour is identical.
// TESTING
// - Reset:
//   - Stimulus: rst = 1 for 2 cycles with both valids high.
//   - Required: a_ready = b_ready = 0, all iss outputs 0, then PRIO_A after release.
// - Parallel issue:
//   - Stimulus: a_addr = 8'h05 (write, wdata 8'hAA) and b_addr = 8'h45 (read), same cycle.
//   - Required: both ready. Next cycle: a_iss_bank = 0, a_iss_row = 6'h05, a_iss_wdata = 8'hAA, b_iss_bank = 1, b_iss_row = 6'h05.
// - Conflict round-robin:
//   - Stimulus: both ports hold bank-2 requests (8'h80, 8'h81) for 3 cycles.
//   - Required:
//     - Cycle 1: A granted.
//     - Cycle 2: B granted.
//     - Cycle 3: A granted (B re-requesting).
//     - conflict_cnt = 3 when enabled.
// - Same-address write/write:
//   - Stimulus: a_addr = b_addr = 8'hC3, prio = PRIO_B.
//   - Required: B issues first with its wdata; A issues the following cycle.
// - Reset mid-operation:
//   - Stimulus: conflict pending with B stalled; assert rst for 1 cycle.
//   - Required: B request dropped; after release an A/B conflict grants A first.
// - Counter saturation (ARB_CONFLICT_CNT_EN):
//   - Stimulus: force 65,537 conflicts.
//   - Required: conflict_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/dp_bank_arbiter.sv
// Dual-port bank arbiter: splits A/B requests into bank/row and grants same-bank conflicts round-robin.
// Define ARB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module dp_bank_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int A        = 2,
  parameter int NUM_BANK = 4,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic                a_iss_vld,
  output logic [A-1:0]        a_iss_bank,
  output logic [ADDR_W-A-1:0] a_iss_row,
  output logic                a_iss_we,
  output logic [DATA_W-1:0]   a_iss_wdata,
  output logic                b_iss_vld,
  output logic [A-1:0]        b_iss_bank,
  output logic [ADDR_W-A-1:0] b_iss_row,
  output logic                b_iss_we,
  output logic [DATA_W-1:0]   b_iss_wdata
`ifdef ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]         conflict_cnt
`endif
);

  localparam int ROW_W = ADDR_W - A;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t prio_reg, prio_next;

  // Index 0 is port A, index 1 is port B throughout.
  logic [1:0]        req_vld;
  logic [1:0]        req_we;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [A-1:0]      req_bank  [2];
  logic [ROW_W-1:0]  req_row   [2];
  logic              conflict;

  if (NUM_BANK != 2 ** A) begin : gen_bad_cfg
    $error("NUM_BANK must equal 2**A");
  end

  assign req_vld      = {b_valid, a_valid};
  assign req_we       = {b_we, a_we};
  assign req_addr[0]  = a_addr;
  assign req_addr[1]  = b_addr;
  assign req_wdata[0] = a_wdata;
  assign req_wdata[1] = b_wdata;

  // Read/read on the same bank also counts: the bank has a single access slot per cycle.
  assign conflict = req_vld[0] & req_vld[1] & (req_bank[0] == req_bank[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= PRIO_A;
    end else begin
      prio_reg <= prio_next;
    end
  end

  always_comb begin
    prio_next = prio_reg;
    grant     = 2'b00;
    if (!rst) begin
      grant = req_vld;
      if (conflict) begin
        // The loser of this conflict owns priority for the next one.
        if (prio_reg == PRIO_A) begin
          grant     = 2'b01;
          prio_next = PRIO_B;
        end else begin
          grant     = 2'b10;
          prio_next = PRIO_A;
        end
      end
    end
  end

  assign a_ready = grant[0];
  assign b_ready = grant[1];

  for (genvar gi = 0; gi < 2; gi++) begin : gen_port
    logic              vld_reg;
    logic [A-1:0]      bank_reg;
    logic [ROW_W-1:0]  row_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;

    assign req_bank[gi] = req_addr[gi][ADDR_W-1 -: A];
    assign req_row[gi]  = req_addr[gi][ROW_W-1:0];

    // Payload holds its last captured value when nothing transfers.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg   <= 1'b0;
        bank_reg  <= '0;
        row_reg   <= '0;
        we_reg    <= 1'b0;
        wdata_reg <= '0;
      end else begin
        vld_reg <= grant[gi];
        if (grant[gi]) begin
          bank_reg  <= req_bank[gi];
          row_reg   <= req_row[gi];
          we_reg    <= req_we[gi];
          wdata_reg <= req_wdata[gi];
        end
      end
    end
  end

  assign a_iss_vld   = gen_port[0].vld_reg;
  assign a_iss_bank  = gen_port[0].bank_reg;
  assign a_iss_row   = gen_port[0].row_reg;
  assign a_iss_we    = gen_port[0].we_reg;
  assign a_iss_wdata = gen_port[0].wdata_reg;
  assign b_iss_vld   = gen_port[1].vld_reg;
  assign b_iss_bank  = gen_port[1].bank_reg;
  assign b_iss_row   = gen_port[1].row_reg;
  assign b_iss_we    = gen_port[1].we_reg;
  assign b_iss_wdata = gen_port[1].wdata_reg;

`ifdef ARB_CONFLICT_CNT_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 16'h0000;
    end else if (conflict && cnt_reg != 16'hFFFF) begin
      cnt_reg <= cnt_reg + 16'h0001;
    end
  end

  assign conflict_cnt = cnt_reg;
`endif

endmodule
